// File: rtl/debug_scan_master_if.sv
// Command/response channel between a host agent and debug_scan_master.
// master = host agent side, slave = debug_scan_master side.
interface debug_scan_master_if #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [ADDR_W-1:0] rsp_addr;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_last;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_addr, rsp_data, rsp_last
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, rsp_ready,
    output cmd_ready, rsp_valid, rsp_addr, rsp_data, rsp_last
  );
endinterface

// File: rtl/debug_scan_master.sv
// Command/response engine driving the CPU debug port: run, step, peek and range scan.
// Optional DBG_MULTISTEP_EN: STEP takes its step count from cmd_addr (0 means 1).
module debug_scan_master #(
  parameter int unsigned ADDR_W   = 7,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 40,
  parameter int unsigned STEP_CYC = 2,
  parameter int unsigned SETTLE   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  debug_scan_master_if.slave    host,
  output logic                  busy,
  output logic                  debug_en,
  output logic                  debug_step,
  output logic [ADDR_W-1:0]     debug_addr,
  input  logic [DATA_W-1:0]     debug_data
);

  typedef enum logic [2:0] {
    StIdle, StRunning, StStepHi, StStepLo, StSettle, StSample, StResp
  } state_e;

  localparam logic [1:0]        OpRun  = 2'b00;
  localparam logic [1:0]        OpStep = 2'b01;
  localparam logic [1:0]        OpScan = 2'b10;
  localparam logic [1:0]        OpPeek = 2'b11;
  localparam logic [7:0]        StepLast   = 8'(STEP_CYC - 1);
  localparam logic [7:0]        SettleLast = 8'(SETTLE - 1);
  localparam logic [ADDR_W-1:0] LastAddr   = ADDR_W'(NUM_REGS - 1);

  state_e            state_q;
  logic [7:0]        cnt_q;
  logic [ADDR_W-1:0] steps_q;
  logic              scan_q;
  logic              resume_q;
  logic              rsp_valid_q;
  logic [ADDR_W-1:0] rsp_addr_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic              rsp_last_q;
  logic              idle_or_run;
  logic [ADDR_W-1:0] step_req;

  always_comb begin
`ifdef DBG_MULTISTEP_EN
    step_req = (host.cmd_addr == '0) ? ADDR_W'(1) : host.cmd_addr;
`else
    step_req = ADDR_W'(1);
`endif
  end

  assign idle_or_run    = (state_q == StIdle) || (state_q == StRunning);
  assign busy           = !idle_or_run;
  assign host.cmd_ready = idle_or_run;
  assign host.rsp_valid = rsp_valid_q;
  assign host.rsp_addr  = rsp_addr_q;
  assign host.rsp_data  = rsp_data_q;
  assign host.rsp_last  = rsp_last_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      steps_q     <= '0;
      scan_q      <= 1'b0;
      resume_q    <= 1'b0;
      debug_en    <= 1'b1;
      debug_step  <= 1'b0;
      debug_addr  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_addr_q  <= '0;
      rsp_data_q  <= '0;
      rsp_last_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StRunning: begin
          if (host.cmd_valid) begin
            cnt_q <= '0;
            unique case (host.cmd_op)
              OpRun: begin
                debug_en <= 1'b0;
                state_q  <= StRunning;
              end
              OpStep: begin
                debug_en <= 1'b1;
                steps_q  <= step_req;
                scan_q   <= 1'b0;
                // Coming out of free-run, give the CPU one halted cycle before the pulse.
                resume_q   <= (state_q == StRunning);
                debug_step <= (state_q != StRunning);
                state_q    <= StStepHi;
              end
              OpScan: begin
                debug_en   <= 1'b1;
                debug_addr <= '0;
                scan_q     <= 1'b1;
                state_q    <= StSettle;
              end
              OpPeek: begin
                debug_en   <= 1'b1;
                debug_addr <= host.cmd_addr;
                scan_q     <= 1'b0;
                state_q    <= StSettle;
              end
            endcase
          end
        end
        StStepHi: begin
          if (resume_q) begin
            resume_q   <= 1'b0;
            debug_step <= 1'b1;
          end else if (cnt_q == StepLast) begin
            cnt_q      <= '0;
            debug_step <= 1'b0;
            state_q    <= StStepLo;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        StStepLo: begin
          if (cnt_q == StepLast) begin
            cnt_q <= '0;
            if (steps_q > ADDR_W'(1)) begin
              steps_q    <= steps_q - ADDR_W'(1);
              debug_step <= 1'b1;
              state_q    <= StStepHi;
            end else begin
              state_q <= StSettle;
            end
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        StSettle: begin
          if (cnt_q == SettleLast) begin
            cnt_q   <= '0;
            state_q <= StSample;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        StSample: begin
          rsp_data_q <= debug_data;
          rsp_addr_q <= debug_addr;
          rsp_last_q <= !scan_q || (debug_addr == LastAddr);
          state_q    <= StResp;
        end
        StResp: begin
          if (!rsp_valid_q) begin
            rsp_valid_q <= 1'b1;
          end else if (host.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            if (scan_q && (debug_addr != LastAddr)) begin
              debug_addr <= debug_addr + ADDR_W'(1);
              state_q    <= StSettle;
            end else begin
              scan_q  <= 1'b0;
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_scan_master.sv
// Scoreboard bench for debug_scan_master: expected words queued at command issue,
// compared as the DUT hands them over; a small CPU model answers debug reads.
module tb_debug_scan_master;
  localparam int unsigned AW = 7;
  localparam int unsigned DW = 32;
  localparam int unsigned NR = 40;
  localparam int unsigned SC = 2;
  localparam int unsigned ST = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          busy, debug_en, debug_step;
  logic [AW-1:0] debug_addr;
  logic [DW-1:0] debug_data;

  debug_scan_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  debug_scan_master #(
    .ADDR_W(AW), .DATA_W(DW), .NUM_REGS(NR), .STEP_CYC(SC), .SETTLE(ST)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .host       (bus),
    .busy       (busy),
    .debug_en   (debug_en),
    .debug_step (debug_step),
    .debug_addr (debug_addr),
    .debug_data (debug_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;
  int acc_cyc  = 0;
  int step_cnt = 0;
  int rx_cnt   = 0;
  int last_hi  = 0;
  int last_lo  = 0;
  bit toggle   = 1'b0;
  logic [AW+DW:0] sb[$];

  // CPU model: value depends on the register selected and on how many steps it has taken.
  function automatic logic [DW-1:0] cpu_data(input logic [AW-1:0] a, input int steps);
    return 32'h0040_0000 + {23'd0, a, 2'b00} + (steps << 24);
  endfunction

  assign debug_data = cpu_data(debug_addr, step_cnt);

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [AW+DW:0] pack(input logic [AW-1:0] a, input logic [DW-1:0] d,
                                          input logic l);
    return {a, d, l};
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  always @(posedge debug_step) step_cnt++;

  initial forever begin
    @(posedge clk);
    #1;
    bus.rsp_ready = toggle ? !bus.rsp_ready : 1'b1;
  end

  // Step pulse width tracker
  initial begin
    bit prev = 1'b0;
    bit had  = 1'b0;
    int hi = 0;
    int lo = 0;
    forever begin
      @(negedge clk);
      if (debug_step && !prev) begin
        if (had) last_lo = lo;
        hi = 1;
      end else if (debug_step) begin
        hi++;
      end else if (prev) begin
        last_hi = hi;
        lo = 1;
        had = 1'b1;
      end else begin
        lo++;
      end
      prev = debug_step;
    end
  end

  // Response monitor
  initial begin
    bit stalled = 1'b0;
    logic [AW+DW:0] held;
    logic [AW+DW:0] got;
    logic [AW+DW:0] exp;
    forever begin
      @(negedge clk);
      if (!rst) begin
        stalled = 1'b0;
      end else if (bus.rsp_valid) begin
        got = pack(bus.rsp_addr, bus.rsp_data, bus.rsp_last);
        if (stalled) check_eq("rsp_hold", got, held);
        if (bus.rsp_ready) begin
          stalled = 1'b0;
          rx_cnt++;
          if (sb.size() == 0) begin
            check_eq("rsp_unexpected", 64'(sb.size()), 64'd1);
          end else begin
            exp = sb.pop_front();
            check_eq("rsp_addr", got[AW+DW:DW+1], exp[AW+DW:DW+1]);
            check_eq("rsp_data", got[DW:1], exp[DW:1]);
            check_eq("rsp_last", got[0], exp[0]);
          end
        end else begin
          stalled = 1'b1;
          held = got;
        end
      end else begin
        if (stalled) check_eq("rsp_valid_hold", bus.rsp_valid, 1'b1);
        stalled = 1'b0;
      end
    end
  end

  task automatic send_cmd(input logic [1:0] op, input logic [AW-1:0] a);
    int n = 0;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_addr  = a;
    while (!bus.cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("cmd_accept", 64'(n < 100), 64'd1);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic check_latency(input string tag, input int exp_lat);
    int n = 0;
    while (!bus.rsp_valid && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq(tag, 64'(cyc - acc_cyc), 64'(exp_lat));
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    while ((sb.size() != 0 || busy) && n < limit) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("done_in_time", 64'(n < limit), 64'd1);
  endtask

  task automatic push_scan();
    for (int a = 0; a < NR; a++)
      sb.push_back(pack(AW'(a), cpu_data(AW'(a), step_cnt), a == NR - 1));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_en"}, debug_en, 1'b1);
    check_eq({tag, "_step"}, debug_step, 1'b0);
    check_eq({tag, "_addr"}, debug_addr, '0);
    check_eq({tag, "_rsp_valid"}, bus.rsp_valid, 1'b0);
    check_eq({tag, "_rsp_addr"}, bus.rsp_addr, '0);
    check_eq({tag, "_rsp_data"}, bus.rsp_data, '0);
    check_eq({tag, "_rsp_last"}, bus.rsp_last, 1'b0);
    check_eq({tag, "_busy"}, busy, 1'b0);
    check_eq({tag, "_cmd_ready"}, bus.cmd_ready, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n_step;
    int s0;
    int r0;
    int n;
    rst           = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_addr  = '0;
    bus.rsp_ready = 1'b1;
    #100;
    check_reset_outputs("rst_hold");
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("rst_rel");

    // PEEK 8
    sb.push_back(pack(7'd8, 32'h0040_0020, 1'b1));
    send_cmd(2'b11, 7'd8);
    check_eq("peek_addr", debug_addr, 7'd8);
    check_eq("peek_busy", busy, 1'b1);
    check_latency("peek_lat", ST + 2);
    wait_done(100);

    // PEEK beyond the scan range
    sb.push_back(pack(7'd100, cpu_data(7'd100, step_cnt), 1'b1));
    send_cmd(2'b11, 7'd100);
    check_latency("peek_hi_lat", ST + 2);
    wait_done(100);

    // STEP with cmd_addr=3: three steps only with the multistep build
`ifdef DBG_MULTISTEP_EN
    n_step = 3;
`else
    n_step = 1;
`endif
    s0 = step_cnt;
    sb.push_back(pack(7'd100, cpu_data(7'd100, s0 + n_step), 1'b1));
    send_cmd(2'b01, 7'd3);
    check_latency("step_lat", 2 * SC * n_step + ST + 2);
    wait_done(200);
    check_eq("step_edges", 64'(step_cnt - s0), 64'(n_step));
    check_eq("step_hi_width", 64'(last_hi), 64'(SC));
`ifdef DBG_MULTISTEP_EN
    check_eq("step_lo_width", 64'(last_lo), 64'(SC));
`endif
    check_eq("step_busy_after", busy, 1'b0);
    check_eq("step_en_after", debug_en, 1'b1);

    // SCAN with rsp_ready toggling every cycle
    toggle = 1'b1;
    push_scan();
    r0 = rx_cnt;
    send_cmd(2'b10, 7'd0);
    wait_done(3000);
    toggle = 1'b0;
    check_eq("scan_words", 64'(rx_cnt - r0), 64'(NR));
    check_eq("scan_addr_kept", debug_addr, 7'(NR - 1));

    // RUN, RUN again, then PEEK 5 out of free-run
    send_cmd(2'b00, 7'd0);
    check_eq("run_en", debug_en, 1'b0);
    check_eq("run_busy", busy, 1'b0);
    check_eq("run_ready", bus.cmd_ready, 1'b1);
    send_cmd(2'b00, 7'd0);
    check_eq("run_again_en", debug_en, 1'b0);
    sb.push_back(pack(7'd5, cpu_data(7'd5, step_cnt), 1'b1));
    send_cmd(2'b11, 7'd5);
    check_eq("run_peek_en", debug_en, 1'b1);
    check_latency("run_peek_lat", ST + 2);
    wait_done(100);

    // Reset in the middle of a SCAN while address 17 is presented
    toggle = 1'b1;
    push_scan();
    send_cmd(2'b10, 7'd0);
    n = 0;
    while (!(bus.rsp_valid && bus.rsp_addr == 7'd17) && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("scan17_seen", 64'(n < 2000), 64'd1);
    rst = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    sb.delete();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    toggle = 1'b0;
    push_scan();
    r0 = rx_cnt;
    send_cmd(2'b10, 7'd0);
    wait_done(3000);
    check_eq("rescan_words", 64'(rx_cnt - r0), 64'(NR));

    check_eq("sb_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule

// File: doc/debug_scan_master.md
Name: debug_scan_master

Overview:
- Host-side controller for the CPU debug port. It drives debug_en, debug_step and debug_addr, and samples debug_data.
- Replaces free-running testbench toggling with a command/response engine that can run, single-step, peek one debug address, or scan a range of debug addresses.
- Sits between the top-level mips instance and a host agent (UART bridge, display driver or bench). It uses a valid/ready command channel in and a valid/ready response channel out.

Parameters:
- ADDR_W, 7, width of debug_addr and rsp_addr.
- DATA_W, 32, width of debug_data and rsp_data.
- NUM_REGS, 40, scan covers debug addresses 0..NUM_REGS-1; must satisfy NUM_REGS <= 2**ADDR_W.
- STEP_CYC, 2, cycles debug_step is held high, then held low, per step.
- SETTLE, 2, cycles waited after a debug_addr change before debug_data is sampled; minimum 1.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  command accepted when cmd_valid and cmd_ready are both high.
- cmd_op  input  2  00 RUN, 01 STEP, 10 SCAN, 11 PEEK.
- cmd_addr  input  ADDR_W  PEEK address; step count under the optional feature.
- rsp_valid  output  1  response word present.
- rsp_ready  input  1  response consumed when rsp_valid and rsp_ready are both high.
- rsp_addr  output  ADDR_W  debug address of the response word.
- rsp_data  output  DATA_W  sampled debug_data.
- rsp_last  output  1  final word of a SCAN; also high on PEEK and STEP responses.
- busy  output  1  high in every state except IDLE and RUNNING.
- debug_en  output  1  1 = CPU halted under debug control, 0 = CPU free-running.
- debug_step  output  1  step pulse to CPU; the CPU advances on each rising edge.
- debug_addr  output  ADDR_W  debug register select.
- debug_data  input  DATA_W  debug register value from the CPU.

Behaviour:
- Reset values (rst low, asynchronous):
  - debug_en=1, debug_step=0, debug_addr=0.
  - rsp_valid=0, rsp_addr=0, rsp_data=0, rsp_last=0.
  - busy=0, cmd_ready=1.
  - State IDLE, all counters 0.
- States: IDLE, RUNNING, STEP_HI, STEP_LO, SETTLE, SAMPLE, RESP.
- cmd_ready=1 only in IDLE and RUNNING. A command is accepted on the edge where cmd_valid and cmd_ready are both high.
- RUN (from IDLE):
  - debug_en goes to 0 on the next edge; go to RUNNING. No response is produced.
  - RUN while already RUNNING is accepted with no effect.
- Any non-RUN command while RUNNING:
  - debug_en goes to 1 on the accept edge, then the command executes as if issued from IDLE.
  - Step timing begins one cycle after debug_en=1.
- STEP:
  - STEP_HI holds debug_step=1 for STEP_CYC cycles; STEP_LO holds debug_step=0 for STEP_CYC cycles.
  - Then SETTLE, then SAMPLE of the current debug_addr.
  - Then RESP with rsp_last=1 and rsp_addr equal to the current debug_addr.
  - Exactly one rising edge of debug_step per step.
- PEEK:
  - debug_addr<=cmd_addr on the accept edge.
  - SETTLE for SETTLE cycles, then SAMPLE latches debug_data into rsp_data, then RESP with rsp_last=1.
  - Any 7-bit address is legal, including addresses >= NUM_REGS.
- SCAN:
  - debug_addr<=0, then per address: SETTLE, SAMPLE, RESP.
  - After a handshake in RESP: if debug_addr==NUM_REGS-1, go to IDLE; otherwise debug_addr+1 and back to SETTLE.
  - rsp_last=1 only on address NUM_REGS-1.
  - Produces exactly NUM_REGS words in ascending order.
- RESP:
  - rsp_valid=1 with rsp_addr/rsp_data/rsp_last held stable until the handshake; rsp_ready back-pressure stalls indefinitely.
  - rsp_valid falls on the edge after the handshake.
  - Back-to-back SCAN words are separated by at least SETTLE+1 cycles.
- debug_addr keeps its last value after any command. The CPU stays halted (debug_en=1) after STEP, PEEK and SCAN.
- Reset asserted mid-operation aborts immediately to the reset values. A partial SCAN is not resumed, and a pending response is discarded.
- Latency:
  - PEEK accept to rsp_valid = SETTLE+2 cycles.
  - STEP accept to rsp_valid = 2*STEP_CYC+SETTLE+2 cycles.

Optional Feature:
- Macro DBG_MULTISTEP_EN.
- Defined: STEP uses cmd_addr as a step count N, where N=0 is treated as 1. STEP_HI/STEP_LO repeat N times, giving N rising edges of debug_step, before the single response.
- Not defined: cmd_addr is ignored for STEP and exactly one step is issued.

Test Plan:
- Reset: hold rst=0 for 100 ns then release -> debug_en=1, debug_step=0, debug_addr=0, rsp_valid=0, cmd_ready=1.
- PEEK with cmd_addr=8, CPU returns 0x0040_0020, rsp_ready=1 -> debug_addr=8; rsp_valid rises 4 cycles after accept (SETTLE=2) with rsp_addr=8, rsp_data=0x0040_0020, rsp_last=1.
- STEP from halted -> one debug_step high pulse of 2 cycles followed by 2 low cycles; one response, rsp_last=1; busy=0 afterwards. With DBG_MULTISTEP_EN defined and cmd_addr=3 -> 3 rising edges and one response.
- SCAN with rsp_ready toggling 1/0 each cycle -> 40 responses, addresses 0..39 ascending, data stable while stalled, rsp_last only at address 39.
- RUN then PEEK addr 5 -> debug_en=0 after RUN; debug_en=1 on the PEEK accept edge; response for address 5 follows.
- Assert rst=0 during SCAN at address 17 with rsp_valid=1 -> all outputs return to reset values immediately; a new SCAN after release restarts at address 0.
